controller_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle fetch/execute controller FSM in the microcontroller datapath.
- Adds an instruction-memory request/acknowledge handshake, an optional multi-cycle ALU wait, CALL/RET with a return-address stack pointer, sticky HALT with resume, and a fault state.
- Drives the same datapath strobes (PC, IR, register, accumulator, ALU).

---
 rtl/controller_pkg.sv | 64 ++++++
 rtl/controller_decode.sv | 112 +++++++++++
 rtl/controller_mc.sv | 177 +++++++++++++++++
 tb/tb_controller_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multi-cycle fetch/execute controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_ALU_WAIT,
        ST_HALTED,
        ST_FAULT
    } state_t;

    // Opcodes (4-bit base encoding; wider opcode buses zero-extend these)
    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_NOR    = 4'b0011;
    localparam logic [3:0] OP_MOV_RA = 4'b0100;
    localparam logic [3:0] OP_MOV_AR = 4'b0101;
    localparam logic [3:0] OP_JZ_REG = 4'b0110;
    localparam logic [3:0] OP_JZ_IMM = 4'b0111;
    localparam logic [3:0] OP_JC_REG = 4'b1000;
    localparam logic [3:0] OP_CALL   = 4'b1001;
    localparam logic [3:0] OP_JC_IMM = 4'b1010;
    localparam logic [3:0] OP_SHL    = 4'b1011;
    localparam logic [3:0] OP_SHR    = 4'b1100;
    localparam logic [3:0] OP_LDIMM  = 4'b1101;
    localparam logic [3:0] OP_RET    = 4'b1110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    // PC source select
    localparam logic [1:0] PCSEL_IMM = 2'd0;
    localparam logic [1:0] PCSEL_REG = 2'd1;
    localparam logic [1:0] PCSEL_STK = 2'd2;

    // Accumulator source select
    localparam logic [1:0] ACCSEL_ALU = 2'd0;
    localparam logic [1:0] ACCSEL_REG = 2'd2;
    localparam logic [1:0] ACCSEL_IMM = 2'd3;

    // ALU function codes
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_HOLD = 4'b1000;
    localparam logic [3:0] ALU_ADD  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SHL  = 4'b0001;
    localparam logic [3:0] ALU_SHR  = 4'b0011;

    // Maps an ALU opcode to its function code; ALU_NONE for non-ALU opcodes
    function automatic logic [3:0] alu_func(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_NOR:  return ALU_NOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/controller_decode.sv
// EXEC-state decoder: opcode + flags + stack status -> datapath strobe bundle.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the FSM decides when the bundle is used.
module controller_decode
    import controller_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int ALUSELW = 4,
    parameter int MC_ALU  = 0
) (
    input  logic [OPW-1:0]     opcode,
    input  logic               zflag,
    input  logic               cflag,
    input  logic               stk_full,
    input  logic               stk_empty,
    output logic               inc_pc,
    output logic               load_pc,
    output logic [1:0]         sel_pc,
    output logic               load_reg,
    output logic               load_acc,
    output logic               load_alu,
    output logic [1:0]         sel_acc,
    output logic [ALUSELW-1:0] sel_alu,
    output logic               push,
    output logic               pop,
    output logic               to_alu_wait,
    output logic               to_halt,
    output logic               to_fault
);

    logic [3:0] op4;

    // Decode one instruction; opcodes outside the 4-bit map fall through as NOP
    always_comb begin
        op4         = (opcode <= OPW'(4'hF)) ? opcode[3:0] : OP_NOP;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        sel_pc      = PCSEL_IMM;
        load_reg    = 1'b0;
        load_acc    = 1'b0;
        load_alu    = 1'b0;
        sel_acc     = ACCSEL_ALU;
        sel_alu     = '0;
        push        = 1'b0;
        pop         = 1'b0;
        to_alu_wait = 1'b0;
        to_halt     = 1'b0;
        to_fault    = 1'b0;
        case (op4)
            OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
                load_alu = 1'b1;
                sel_acc  = ACCSEL_ALU;
                sel_alu  = ALUSELW'(alu_func(op4));
                if (MC_ALU != 0) begin
                    to_alu_wait = 1'b1;
                end else begin
                    load_acc = 1'b1;
                    inc_pc   = 1'b1;
                end
            end
            OP_MOV_RA: begin
                sel_acc  = ACCSEL_REG;
                load_acc = 1'b1;
                inc_pc   = 1'b1;
            end
            OP_MOV_AR: begin
                load_reg = 1'b1;
                inc_pc   = 1'b1;
            end
            OP_LDIMM: begin
                sel_acc  = ACCSEL_IMM;
                load_acc = 1'b1;
                inc_pc   = 1'b1;
            end
            OP_JZ_REG, OP_JZ_IMM: begin
                sel_pc  = (op4 == OP_JZ_REG) ? PCSEL_REG : PCSEL_IMM;
                load_pc = zflag;
                inc_pc  = ~zflag;
            end
            OP_JC_REG, OP_JC_IMM: begin
                sel_pc  = (op4 == OP_JC_REG) ? PCSEL_REG : PCSEL_IMM;
                load_pc = cflag;
                inc_pc  = ~cflag;
            end
            OP_CALL: begin
                if (stk_full) begin
                    to_fault = 1'b1;
                end else begin
                    push    = 1'b1;
                    sel_pc  = PCSEL_IMM;
                    load_pc = 1'b1;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    to_fault = 1'b1;
                end else begin
                    pop     = 1'b1;
                    sel_pc  = PCSEL_STK;
                    load_pc = 1'b1;
                end
            end
            OP_HALT: begin
                to_halt = 1'b1;
            end
            default: begin
                inc_pc = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/controller_mc.sv
// Multi-cycle fetch/execute controller with return stack pointer, HALT/resume and sticky FAULT.
// Latency: 2 cycles per instruction minimum, +1 per cycle imem_ack is low, +>=1 for ALU ops when MC_ALU=1.
// Backpressure: stalls in FETCH until imem_ack and in ALU_WAIT until alu_done.
module controller_mc
    import controller_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int ALUSELW     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SPW         = 3,
    parameter int MC_ALU      = 0
) (
    input  logic               clk,
    input  logic               clb,
    input  logic [OPW-1:0]     opcode,
    input  logic               zflag,
    input  logic               cflag,
    input  logic               imem_ack,
    input  logic               alu_done,
    input  logic               resume,
    output logic               imem_req,
    output logic               loadIR,
    output logic               incPC,
    output logic               loadPC,
    output logic [1:0]         selPC,
    output logic               loadReg,
    output logic               loadAcc,
    output logic               loadAlu,
    output logic [1:0]         selAcc,
    output logic [ALUSELW-1:0] selAlu,
    output logic               push,
    output logic               pop,
    output logic [SPW-1:0]     sp,
    output logic               halted,
    output logic               fault
);

    state_t               state;
    logic                 stk_full;
    logic                 stk_empty;
    logic                 dec_inc_pc;
    logic                 dec_load_pc;
    logic [1:0]           dec_sel_pc;
    logic                 dec_load_reg;
    logic                 dec_load_acc;
    logic                 dec_load_alu;
    logic [1:0]           dec_sel_acc;
    logic [ALUSELW-1:0]   dec_sel_alu;
    logic                 dec_push;
    logic                 dec_pop;
    logic                 dec_to_alu_wait;
    logic                 dec_to_halt;
    logic                 dec_to_fault;

    assign stk_full  = (sp == SPW'(STACK_DEPTH));
    assign stk_empty = (sp == '0);

    controller_decode #(
        .OPW     (OPW),
        .ALUSELW (ALUSELW),
        .MC_ALU  (MC_ALU)
    ) u_decode (
        .opcode      (opcode),
        .zflag       (zflag),
        .cflag       (cflag),
        .stk_full    (stk_full),
        .stk_empty   (stk_empty),
        .inc_pc      (dec_inc_pc),
        .load_pc     (dec_load_pc),
        .sel_pc      (dec_sel_pc),
        .load_reg    (dec_load_reg),
        .load_acc    (dec_load_acc),
        .load_alu    (dec_load_alu),
        .sel_acc     (dec_sel_acc),
        .sel_alu     (dec_sel_alu),
        .push        (dec_push),
        .pop         (dec_pop),
        .to_alu_wait (dec_to_alu_wait),
        .to_halt     (dec_to_halt),
        .to_fault    (dec_to_fault)
    );

    // Datapath strobes per state; decoder bundle only reaches the pins in EXEC
    always_comb begin
        imem_req = 1'b0;
        loadIR   = 1'b0;
        incPC    = 1'b0;
        loadPC   = 1'b0;
        selPC    = PCSEL_IMM;
        loadReg  = 1'b0;
        loadAcc  = 1'b0;
        loadAlu  = 1'b0;
        selAcc   = ACCSEL_ALU;
        selAlu   = '0;
        push     = 1'b0;
        pop      = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                selAlu   = ALUSELW'(ALU_HOLD);
                loadIR   = imem_ack;
            end
            ST_EXEC: begin
                incPC   = dec_inc_pc;
                loadPC  = dec_load_pc;
                selPC   = dec_sel_pc;
                loadReg = dec_load_reg;
                loadAcc = dec_load_acc;
                loadAlu = dec_load_alu;
                selAcc  = dec_sel_acc;
                selAlu  = dec_sel_alu;
                push    = dec_push;
                pop     = dec_pop;
            end
            ST_ALU_WAIT: begin
                // IR still holds the ALU opcode, so the decoder keeps selAlu stable
                loadAlu = 1'b1;
                selAlu  = dec_sel_alu;
                selAcc  = ACCSEL_ALU;
                loadAcc = alu_done;
                incPC   = alu_done;
            end
            ST_HALTED: begin
                halted = 1'b1;
                incPC  = resume;
            end
            default: begin
            end
        endcase
    end

    // State sequencing, return-stack pointer and sticky fault flag
    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            state <= ST_IDLE;
            sp    <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_to_fault) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else if (dec_to_alu_wait) begin
                        state <= ST_ALU_WAIT;
                    end else if (dec_to_halt) begin
                        state <= ST_HALTED;
                    end else begin
                        state <= ST_FETCH;
                    end
                    if (dec_push) sp <= sp + SPW'(1);
                    if (dec_pop)  sp <= sp - SPW'(1);
                end
                ST_ALU_WAIT: begin
                    if (alu_done) state <= ST_FETCH;
                end
                ST_HALTED: begin
                    if (resume) state <= ST_FETCH;
                end
                ST_FAULT: begin
                    fault <= 1'b1;
                end
                default: begin
                    // unused encodings are treated as a fault
                    state <= ST_FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_mc.sv
// Bench for controller_mc: two instances (single-cycle and multi-cycle ALU) with independent inputs.
// Each cycle both are compared against an instruction-level reference model.
// Directed scenarios first, then randomized traffic with periodic resets.
module tb_controller_mc;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_WAIT  = 3;
    localparam int P_HALT  = 4;
    localparam int P_FAULT = 5;

    logic       clk = 1'b0;
    logic       clb;
    logic [3:0] opc [2];
    logic       zf [2], cf [2], ack [2], dn [2], rs [2];

    logic       req_w [2], ir_w [2], inc_w [2], ldpc_w [2], ldreg_w [2], ldacc_w [2];
    logic       ldalu_w [2], push_w [2], pop_w [2], hlt_w [2], flt_w [2];
    logic [1:0] selpc_w [2], selacc_w [2];
    logic [3:0] selalu_w [2];
    logic [2:0] sp_w [2];

    int ph [2];
    int dep [2];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    controller_mc #(.MC_ALU(0)) u0 (
        .clk(clk), .clb(clb), .opcode(opc[0]), .zflag(zf[0]), .cflag(cf[0]),
        .imem_ack(ack[0]), .alu_done(dn[0]), .resume(rs[0]),
        .imem_req(req_w[0]), .loadIR(ir_w[0]), .incPC(inc_w[0]), .loadPC(ldpc_w[0]),
        .selPC(selpc_w[0]), .loadReg(ldreg_w[0]), .loadAcc(ldacc_w[0]), .loadAlu(ldalu_w[0]),
        .selAcc(selacc_w[0]), .selAlu(selalu_w[0]), .push(push_w[0]), .pop(pop_w[0]),
        .sp(sp_w[0]), .halted(hlt_w[0]), .fault(flt_w[0])
    );

    controller_mc #(.MC_ALU(1)) u1 (
        .clk(clk), .clb(clb), .opcode(opc[1]), .zflag(zf[1]), .cflag(cf[1]),
        .imem_ack(ack[1]), .alu_done(dn[1]), .resume(rs[1]),
        .imem_req(req_w[1]), .loadIR(ir_w[1]), .incPC(inc_w[1]), .loadPC(ldpc_w[1]),
        .selPC(selpc_w[1]), .loadReg(ldreg_w[1]), .loadAcc(ldacc_w[1]), .loadAlu(ldalu_w[1]),
        .selAcc(selacc_w[1]), .selAlu(selalu_w[1]), .push(push_w[1]), .pop(pop_w[1]),
        .sp(sp_w[1]), .halted(hlt_w[1]), .fault(flt_w[1])
    );

    function automatic logic [18:0] obs(input int i);
        return {req_w[i], ir_w[i], inc_w[i], ldpc_w[i], selpc_w[i], ldreg_w[i], ldacc_w[i],
                ldalu_w[i], selacc_w[i], selalu_w[i], push_w[i], pop_w[i], hlt_w[i], flt_w[i]};
    endfunction

    function automatic int alu_code(input logic [3:0] op);
        case (op)
            4'd1:    return 9;
            4'd2:    return 12;
            4'd3:    return 4;
            4'd11:   return 1;
            4'd12:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
        n_assert++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, x);
        end
    endtask

    // Reference: expected pins this cycle plus where the instruction goes next
    task automatic model(input int i, output logic [18:0] e, output int nph, output int nd);
        logic       req, ir, inc, ldpc, ldreg, ldacc, ldalu, psh, pp, hlt, flt;
        logic [1:0] spc, sac;
        logic [3:0] sal;
        int         a;
        {req, ir, inc, ldpc, ldreg, ldacc, ldalu, psh, pp, hlt, flt} = '0;
        spc = 2'd0;
        sac = 2'd0;
        sal = 4'd0;
        nph = ph[i];
        nd  = dep[i];
        a   = alu_code(opc[i]);
        case (ph[i])
            P_IDLE: nph = P_FETCH;
            P_FETCH: begin
                req = 1'b1;
                sal = 4'b1000;
                if (ack[i]) begin ir = 1'b1; nph = P_EXEC; end
            end
            P_EXEC: begin
                nph = P_FETCH;
                if (a >= 0) begin
                    ldalu = 1'b1;
                    sal   = a[3:0];
                    if (i == 1) nph = P_WAIT;
                    else begin ldacc = 1'b1; inc = 1'b1; end
                end else begin
                    case (opc[i])
                        4'd4:  begin sac = 2'd2; ldacc = 1'b1; inc = 1'b1; end
                        4'd5:  begin ldreg = 1'b1; inc = 1'b1; end
                        4'd13: begin sac = 2'd3; ldacc = 1'b1; inc = 1'b1; end
                        4'd6, 4'd7: begin
                            spc = (opc[i] == 4'd6) ? 2'd1 : 2'd0;
                            ldpc = zf[i]; inc = !zf[i];
                        end
                        4'd8, 4'd10: begin
                            spc = (opc[i] == 4'd8) ? 2'd1 : 2'd0;
                            ldpc = cf[i]; inc = !cf[i];
                        end
                        4'd9: begin
                            if (dep[i] == 4) nph = P_FAULT;
                            else begin psh = 1'b1; ldpc = 1'b1; nd = dep[i] + 1; end
                        end
                        4'd14: begin
                            if (dep[i] == 0) nph = P_FAULT;
                            else begin pp = 1'b1; spc = 2'd2; ldpc = 1'b1; nd = dep[i] - 1; end
                        end
                        4'd15: nph = P_HALT;
                        default: inc = 1'b1;
                    endcase
                end
            end
            P_WAIT: begin
                ldalu = 1'b1;
                sal   = a[3:0];
                if (dn[i]) begin ldacc = 1'b1; inc = 1'b1; nph = P_FETCH; end
            end
            P_HALT: begin
                hlt = 1'b1;
                if (rs[i]) begin inc = 1'b1; nph = P_FETCH; end
            end
            default: flt = 1'b1;
        endcase
        e = {req, ir, inc, ldpc, spc, ldreg, ldacc, ldalu, sac, sal, psh, pp, hlt, flt};
    endtask

    // One clock cycle: inputs already driven after a falling edge
    task automatic cycle();
        logic [18:0] e;
        int          nph, nd;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (clb) begin
                e = '0; nph = P_IDLE; nd = 0;
            end else begin
                model(i, e, nph, nd);
            end
            check($sformatf("outs_u%0d", i), 32'(obs(i)), 32'(e));
            check($sformatf("sp_u%0d", i), 32'(sp_w[i]), clb ? 32'd0 : 32'(dep[i]));
            check($sformatf("pc_excl_u%0d", i), 32'(ldpc_w[i] & inc_w[i]), 32'd0);
            ph[i]  = nph;
            dep[i] = nd;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic z, c, a, d, r);
        for (int i = 0; i < 2; i++) begin
            opc[i] = op; zf[i] = z; cf[i] = c; ack[i] = a; dn[i] = d; rs[i] = r;
        end
    endtask

    task automatic do_reset();
        clb = 1'b1;
        cycle();
        clb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clb = 1'b1;
        drive(4'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin ph[i] = P_IDLE; dep[i] = 0; end
        @(negedge clk);
        do_reset();

        // ADD with immediate ack
        drive(4'd1, 0, 0, 1, 0, 0);
        cycle();
        cycle();
        #1 check("add_exec_u0", {28'd0, ldalu_w[0], ldacc_w[0], inc_w[0], ldpc_w[0]}, 32'hE);
        check("add_sel_u0", 32'(selalu_w[0]), 32'h9);
        cycle();
        drive(4'd1, 0, 0, 1, 1, 0);
        cycle();
        do_reset();

        // fetch stalled three cycles
        drive(4'd0, 0, 0, 0, 0, 0);
        cycle();
        repeat (3) cycle();
        ack[0] = 1'b1; ack[1] = 1'b1;
        #1 check("ack_loadir", 32'(ir_w[0]), 32'd1);
        cycle();
        cycle();

        // JZ imm taken and not taken
        drive(4'd7, 1, 0, 1, 0, 0);
        cycle();
        #1 check("jz_taken", {29'd0, ldpc_w[0], inc_w[0], selpc_w[0] == 2'd0}, 32'h5);
        cycle();
        zf[0] = 1'b0; zf[1] = 1'b0;
        cycle();
        #1 check("jz_not", {30'd0, ldpc_w[0], inc_w[0]}, 32'h1);
        cycle();

        // CALL x4, RET x4, overflow and underflow faults
        drive(4'd9, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cycle(); cycle();
            check("call_sp", 32'(sp_w[0]), 32'(k));
        end
        drive(4'd14, 0, 0, 1, 0, 0);
        for (int k = 3; k >= 0; k--) begin
            cycle(); cycle();
            check("ret_sp", 32'(sp_w[0]), 32'(k));
        end
        drive(4'd9, 0, 0, 1, 0, 0);
        repeat (10) cycle();
        check("call_ovf_fault", 32'(flt_w[0]), 32'd1);
        cycle();
        check("fault_sticky", 32'(flt_w[0]), 32'd1);
        do_reset();
        check("fault_clr", {28'd0, flt_w[0], sp_w[0]}, 32'd0);
        drive(4'd14, 0, 0, 1, 0, 0);
        repeat (3) cycle();
        check("ret_udf_fault", 32'(flt_w[1]), 32'd1);
        do_reset();

        // multi-cycle SUB, alu_done on third wait cycle
        drive(4'd2, 0, 0, 1, 0, 0);
        repeat (3) cycle();
        repeat (2) begin
            #1 check("wait_hold", {29'd0, ldalu_w[1], ldacc_w[1], inc_w[1]}, 32'h4);
            cycle();
        end
        dn[0] = 1'b1; dn[1] = 1'b1;
        #1 check("wait_done", {29'd0, ldalu_w[1], ldacc_w[1], inc_w[1]}, 32'h7);
        cycle();
        do_reset();

        // HALT for five cycles then resume
        drive(4'd15, 0, 0, 1, 0, 0);
        repeat (3) cycle();
        repeat (5) begin
            #1 check("halted", 32'(obs(0)), 32'h2);
            cycle();
        end
        rs[0] = 1'b1; rs[1] = 1'b1;
        #1 check("resume_inc", 32'(inc_w[0]), 32'd1);
        cycle();
        rs[0] = 1'b0; rs[1] = 1'b0;
        #1 check("resume_fetch", 32'(req_w[0]), 32'd1);
        cycle();
        do_reset();

        // asynchronous reset in the middle of ALU_WAIT
        drive(4'd1, 0, 0, 1, 0, 0);
        repeat (3) cycle();
        #3 clb = 1'b1;
        #1 check("async_rst_u1", {13'd0, obs(1)}, 32'd0);
        check("async_rst_u0", {13'd0, obs(0)}, 32'd0);
        for (int i = 0; i < 2; i++) begin ph[i] = P_IDLE; dep[i] = 0; end
        @(negedge clk);
        cycle();
        clb = 1'b0;

        // randomized traffic, opcode only changes between instructions
        for (int n = 1; n <= 3000; n++) begin
            clb = (n % 97 == 0);
            for (int i = 0; i < 2; i++) begin
                if (ph[i] != P_EXEC && ph[i] != P_WAIT) begin
                    int r;
                    r = $urandom_range(0, 19);
                    if (r < 16)      opc[i] = 4'(r);
                    else if (r < 19) opc[i] = 4'd9;
                    else             opc[i] = 4'd14;
                end
                zf[i]  = 1'($urandom_range(0, 1));
                cf[i]  = 1'($urandom_range(0, 1));
                ack[i] = ($urandom_range(0, 9) < 6);
                dn[i]  = ($urandom_range(0, 9) < 4);
                rs[i]  = ($urandom_range(0, 9) < 3);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
